// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one icache request at a time,
// pre-decodes the returned word (length + static branch prediction) and feeds the IQ.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        to_icache,
  output logic [31:0] pc,
  input  logic        have_result,
  input  logic [31:0] inst_in,
  input  logic        iq_full,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        iq_is_c,
  output logic        iq_pred_taken,
  output logic [31:0] iq_pred_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_t;

  state_t      state;
  logic        discard;
  logic [31:0] redirect_pc;

  logic        dec_is_c;
  logic        dec_taken;
  logic [31:0] dec_inst;
  logic [31:0] dec_next;
  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] imm_cj;
  logic [31:0] imm_cb;

  always_comb begin
    imm_j  = {{12{inst_in[31]}}, inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};
    imm_b  = {{20{inst_in[31]}}, inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
    imm_cj = {{21{inst_in[12]}}, inst_in[8], inst_in[10:9], inst_in[6], inst_in[7],
              inst_in[2], inst_in[11], inst_in[5:3], 1'b0};
    imm_cb = {{24{inst_in[12]}}, inst_in[6:5], inst_in[2], inst_in[11:10], inst_in[4:3], 1'b0};

    dec_is_c  = (inst_in[1:0] != 2'b11);
    seq_pc    = pc + (dec_is_c ? 32'd2 : 32'd4);
    dec_taken = 1'b0;
    br_target = seq_pc;

    if (!dec_is_c) begin
      if (inst_in[6:0] == 7'b1101111) begin
        dec_taken = 1'b1;
        br_target = pc + imm_j;
      end else if (inst_in[6:0] == 7'b1100011) begin
        dec_taken = inst_in[31];
        br_target = pc + imm_b;
      end
    end else if (inst_in[1:0] == 2'b01) begin
      if (inst_in[15:13] == 3'b101) begin
        dec_taken = 1'b1;
        br_target = pc + imm_cj;
      end else if (inst_in[15:14] == 2'b11) begin
        dec_taken = inst_in[12];
        br_target = pc + imm_cb;
      end
    end

    dec_next = dec_taken ? br_target : seq_pc;
    dec_inst = dec_is_c ? {16'h0000, inst_in[15:0]} : inst_in;
  end

  // Request is decoded from the registered state so that IQ acceptance and the
  // next request land in the same cycle (two-cycle hit throughput).
  assign to_icache = !rst && rdy && !flush &&
                     ((state == ISSUE) || ((state == HOLD) && !iq_full));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ISSUE;
      pc            <= RESET_PC;
      discard       <= 1'b0;
      redirect_pc   <= '0;
      iq_valid      <= 1'b0;
      iq_inst       <= '0;
      iq_pc         <= '0;
      iq_is_c       <= 1'b0;
      iq_pred_taken <= 1'b0;
      iq_pred_pc    <= '0;
    end else if (rdy) begin
      if (flush) begin
        iq_valid <= 1'b0;
        if (state == WAIT && !have_result) begin
          // Outstanding request: redirect is deferred until the stale response returns.
          discard     <= 1'b1;
          redirect_pc <= flush_pc;
        end else begin
          discard <= 1'b0;
          pc      <= flush_pc;
          state   <= ISSUE;
        end
      end else begin
        case (state)
          ISSUE: state <= WAIT;
          WAIT: begin
            if (have_result) begin
              if (discard) begin
                discard <= 1'b0;
                pc      <= redirect_pc;
                state   <= ISSUE;
              end else begin
                iq_valid      <= 1'b1;
                iq_inst       <= dec_inst;
                iq_pc         <= pc;
                iq_is_c       <= dec_is_c;
                iq_pred_taken <= dec_taken;
                iq_pred_pc    <= dec_next;
                pc            <= dec_next;
                state         <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!iq_full) begin
              iq_valid <= 1'b0;
              state    <= WAIT;
            end
          end
          default: state <= ISSUE;
        endcase
      end
    end
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction cache.
- Owns the architectural fetch PC and issues one request at a time to the icache: a one-cycle to_icache pulse, then PC held stable until have_result.
- Pre-decodes each returned word: 32-bit vs compressed length, plus static branch prediction.
- Pushes {inst, pc, prediction} to the instruction queue; honours back-pressure and redirect (flush) from the ROB.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
rdy  input  1  global enable; when low, all state frozen
to_icache  output  1  one-cycle request pulse to icache
pc  output  32  fetch address; stable from request until have_result
have_result  input  1  icache response strobe, one cycle
inst_in  input  32  icache data, valid with have_result
iq_full  input  1  instruction queue cannot accept this cycle
iq_valid  output  1  instruction presented to queue (accepted when !iq_full)
iq_inst  output  32  instruction; compressed: upper 16 bits zeroed
iq_pc  output  32  address of iq_inst
iq_is_c  output  1  instruction is 16-bit
iq_pred_taken  output  1  predicted taken
iq_pred_pc  output  32  predicted next PC
flush  input  1  redirect from ROB
flush_pc  input  32  redirect target

Behaviour:
- Reset (async): state=ISSUE, pc=RESET_PC, discard=0; to_icache, iq_valid, iq_pred_taken, iq_is_c = 0; iq_inst, iq_pc, iq_pred_pc = 0.
- All sequential updates gated by rdy (rdy low: hold everything, including pulses).
- States ISSUE, WAIT, HOLD.
  - ISSUE: if !flush, drive to_icache=1 for exactly one cycle and go to WAIT. to_icache is 0 in every other cycle.
  - WAIT: pc must not change. On have_result:
    - discard=1: drop the data, clear discard, pc<=saved redirect, go to ISSUE.
    - otherwise pre-decode and load the iq_* registers; iq_valid=1 next cycle; pc<=predicted next PC; go to HOLD.
  - HOLD: iq_valid=1. When !iq_full the entry is accepted that cycle: deassert iq_valid and issue the next request in the same cycle (to_icache=1, go to WAIT). If iq_full, hold all iq_* outputs unchanged.
- Hit latency: request cycle T; have_result sampled T+1; iq_valid visible T+2; next request also at T+2 if the queue is not full. Steady hit throughput is 1 instruction per 2 cycles.
- Pre-decode: compressed iff inst_in[1:0]!=2'b11; then iq_is_c=1, next = pc+2, else pc+4.
- Prediction (sign-extended immediates, 32-bit wrap-around add):
  - JAL (opcode 1101111): taken, target pc+imm_j.
  - B-type (1100011): taken iff imm sign bit=1 (backward), target pc+imm_b.
  - C.J (quadrant 01, funct3 101): taken, target pc+imm_cj.
  - C.BEQZ/C.BNEZ (funct3 110/111): backward taken, target pc+imm_cb.
  - JALR, C.JR, C.JALR, C.JAL, all others: not taken.
  - iq_pred_pc = target if taken, else the sequential next PC.
- Flush (highest priority, takes effect the same rdy-cycle):
  - Any state: iq_valid<=0, the pending entry is dropped.
  - ISSUE/HOLD: pc<=flush_pc, go to ISSUE, no to_icache this cycle.
  - WAIT without have_result: pc held, discard<=1, flush_pc saved; the redirect is applied after the stale response. A second flush while discard=1 overwrites the saved target.
  - WAIT coinciding with have_result: the response is dropped, pc<=flush_pc, go to ISSUE.
- Flush and iq acceptance in the same cycle: flush wins; the queue must ignore that entry.

Test Plan:
- Reset release, RESET_PC=0, icache returns 32'h00000013 one cycle after pulse -> iq_valid with iq_pc=0, iq_pred_pc=4, iq_is_c=0; next to_icache pc=4.
- inst_in=32'h0000_4501 (c.li) at pc 8 -> iq_is_c=1, iq_inst=32'h4501, next pc=0xA.
- JAL x0,-8 (32'hFF9FF06F) at pc 0x20 -> iq_pred_taken=1, iq_pred_pc=0x18; forward BEQ +16 at 0x30 -> taken=0, pred_pc=0x34.
- iq_full held 5 cycles during HOLD -> iq_* stable, to_icache stays 0; iq_full drops -> acceptance and next request the same cycle.
- flush(pc=0x100) during WAIT, response 3 cycles later -> response not enqueued, pc stays old until response, then to_icache with pc=0x100.
- rdy low mid-WAIT with have_result pulse held -> no state change; async rst mid-WAIT -> all outputs zero immediately, pc=RESET_PC.
